apsr_flag_unit: RTL and testbench

APSR_FLAG_UNIT -- requirements
Module: apsr_flag_unit

---
 rtl/apsr_flag_unit_pkg.sv | 37 +++
 rtl/apsr_cond_eval.sv | 39 +++
 rtl/apsr_flag_unit.sv | 111 +++++++++++
 tb/tb_apsr_flag_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apsr_flag_unit_pkg.sv
// Shared core definitions for the APSR flag unit: carry-source select encodings,
// Thumb condition codes and NZCV bit positions.
package apsr_flag_unit_pkg;

   typedef enum logic [1:0] {
      C_SRC_ALU   = 2'd0,
      C_SRC_SHIFT = 2'd1,
      C_SRC_HOLD  = 2'd2,
      C_SRC_RSVD  = 2'd3
   } c_src_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_CS = 4'h2,
      COND_CC = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'hA,
      COND_LT = 4'hB,
      COND_GT = 4'hC,
      COND_LE = 4'hD,
      COND_AL = 4'hE,
      COND_NV = 4'hF
   } cond_e;

   // Bit positions inside the packed {N,Z,C,V} nibble.
   localparam int unsigned NZCV_N = 3;
   localparam int unsigned NZCV_Z = 2;
   localparam int unsigned NZCV_C = 1;
   localparam int unsigned NZCV_V = 0;

endpackage

// File: rtl/apsr_cond_eval.sv
// Combinational Thumb condition-code evaluator over a packed {N,Z,C,V} nibble.
module apsr_cond_eval
   import apsr_flag_unit_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       cond_pass_o
);

   logic n, z, c, v;

   assign n = nzcv_i[NZCV_N];
   assign z = nzcv_i[NZCV_Z];
   assign c = nzcv_i[NZCV_C];
   assign v = nzcv_i[NZCV_V];

   always_comb begin
      cond_pass_o = 1'b0;
      case (cond_e'(cond_i))
         COND_EQ: cond_pass_o = z;
         COND_NE: cond_pass_o = ~z;
         COND_CS: cond_pass_o = c;
         COND_CC: cond_pass_o = ~c;
         COND_MI: cond_pass_o = n;
         COND_PL: cond_pass_o = ~n;
         COND_VS: cond_pass_o = v;
         COND_VC: cond_pass_o = ~v;
         COND_HI: cond_pass_o = c & ~z;
         COND_LS: cond_pass_o = ~c | z;
         COND_GE: cond_pass_o = (n == v);
         COND_LT: cond_pass_o = (n != v);
         COND_GT: cond_pass_o = ~z & (n == v);
         COND_LE: cond_pass_o = z | (n != v);
         COND_AL: cond_pass_o = 1'b1;
         COND_NV: cond_pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/apsr_flag_unit.sv
// APSR NZCV flag register with per-flag update enables, MSR write and condition check.
// Define APSR_SHADOW_EN to add a one-entry exception shadow (exc_save/exc_restore).
module apsr_flag_unit
   import apsr_flag_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_result,
   input  logic        alu_cout,
   input  logic        alu_vout,
   input  logic        shift_cout,
   input  logic        flag_we_nz,
   input  logic        flag_we_c,
   input  logic        flag_we_v,
   input  logic [1:0]  c_src_sel,
   input  logic        msr_we,
   input  logic [3:0]  msr_data,
   input  logic [3:0]  cond,
`ifdef APSR_SHADOW_EN
   input  logic        exc_save,
   input  logic        exc_restore,
   output logic        shadow_valid,
`endif
   output logic        apsr_n,
   output logic        apsr_z,
   output logic        apsr_c,
   output logic        apsr_v,
   output logic [3:0]  apsr_nzcv,
   output logic        cond_pass
);

   logic [3:0] nzcv_q, nzcv_d;
   logic       restore_fire;

`ifdef APSR_SHADOW_EN
   logic [3:0] shadow_q, shadow_d;
   logic       shadow_valid_q, shadow_valid_d;

   // Restore only fires on a valid shadow; a simultaneous save is dropped.
   assign restore_fire = exc_restore & shadow_valid_q;

   always_comb begin
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q;
      if (exc_restore) begin
         if (shadow_valid_q) shadow_valid_d = 1'b0;
      end else if (exc_save) begin
         shadow_d       = nzcv_q;
         shadow_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q       <= 4'b0000;
         shadow_valid_q <= 1'b0;
      end else begin
         shadow_q       <= shadow_d;
         shadow_valid_q <= shadow_valid_d;
      end
   end

   assign shadow_valid = shadow_valid_q;
`else
   assign restore_fire = 1'b0;
`endif

   always_comb begin
      nzcv_d = nzcv_q;
      if (restore_fire) begin
`ifdef APSR_SHADOW_EN
         nzcv_d = shadow_q;
`endif
      end else if (msr_we) begin
         nzcv_d = msr_data;
      end else begin
         if (flag_we_nz) begin
            nzcv_d[NZCV_N] = alu_result[31];
            nzcv_d[NZCV_Z] = (alu_result == 32'd0);
         end
         if (flag_we_c) begin
            case (c_src_e'(c_src_sel))
               C_SRC_ALU:   nzcv_d[NZCV_C] = alu_cout;
               C_SRC_SHIFT: nzcv_d[NZCV_C] = shift_cout;
               C_SRC_HOLD:  nzcv_d[NZCV_C] = nzcv_q[NZCV_C];
               C_SRC_RSVD:  nzcv_d[NZCV_C] = nzcv_q[NZCV_C];
            endcase
         end
         if (flag_we_v) nzcv_d[NZCV_V] = alu_vout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) nzcv_q <= 4'b0000;
      else     nzcv_q <= nzcv_d;
   end

   assign apsr_n    = nzcv_q[NZCV_N];
   assign apsr_z    = nzcv_q[NZCV_Z];
   assign apsr_c    = nzcv_q[NZCV_C];
   assign apsr_v    = nzcv_q[NZCV_V];
   assign apsr_nzcv = nzcv_q;

   // Evaluated on registered flags only, so a same-cycle update never leaks through.
   apsr_cond_eval u_cond_eval (
      .cond_i      (cond),
      .nzcv_i      (nzcv_q),
      .cond_pass_o (cond_pass)
   );

endmodule

// File: tb/tb_apsr_flag_unit.sv
// Bench for apsr_flag_unit: directed scenarios plus randomized updates against a flag model.
// Shadow scenarios are included when APSR_SHADOW_EN is defined.
module tb_apsr_flag_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_result;
   logic        alu_cout, alu_vout, shift_cout;
   logic        flag_we_nz, flag_we_c, flag_we_v;
   logic [1:0]  c_src_sel;
   logic        msr_we;
   logic [3:0]  msr_data;
   logic [3:0]  cond;
   logic        apsr_n, apsr_z, apsr_c, apsr_v;
   logic [3:0]  apsr_nzcv;
   logic        cond_pass;
`ifdef APSR_SHADOW_EN
   logic        exc_save, exc_restore, shadow_valid;
`endif

   int checks = 0;
   int errors = 0;

   // model state
   bit m_n, m_z, m_c, m_v;
`ifdef APSR_SHADOW_EN
   bit [3:0] m_sh;
   bit       m_sv;
`endif

   apsr_flag_unit dut (
      .clk          (clk),
      .rst          (rst),
      .alu_result   (alu_result),
      .alu_cout     (alu_cout),
      .alu_vout     (alu_vout),
      .shift_cout   (shift_cout),
      .flag_we_nz   (flag_we_nz),
      .flag_we_c    (flag_we_c),
      .flag_we_v    (flag_we_v),
      .c_src_sel    (c_src_sel),
      .msr_we       (msr_we),
      .msr_data     (msr_data),
      .cond         (cond),
`ifdef APSR_SHADOW_EN
      .exc_save     (exc_save),
      .exc_restore  (exc_restore),
      .shadow_valid (shadow_valid),
`endif
      .apsr_n       (apsr_n),
      .apsr_z       (apsr_z),
      .apsr_c       (apsr_c),
      .apsr_v       (apsr_v),
      .apsr_nzcv    (apsr_nzcv),
      .cond_pass    (cond_pass)
   );

   always #5 clk = ~clk;

   // Conditions come in predicate/negation pairs; 14 is always, 15 never.
   function automatic bit ref_cond(input int code, input bit n, input bit z, input bit c, input bit v);
      bit base;
      if (code == 14) return 1'b1;
      if (code == 15) return 1'b0;
      case (code / 2)
         0: base = z;
         1: base = c;
         2: base = n;
         3: base = v;
         4: base = c && !z;
         5: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return (code % 2 == 1) ? !base : base;
   endfunction

   function automatic bit [3:0] m_nzcv();
      return {m_n, m_z, m_c, m_v};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      alu_result = 32'h1; alu_cout = 0; alu_vout = 0; shift_cout = 0;
      flag_we_nz = 0; flag_we_c = 0; flag_we_v = 0; c_src_sel = 2'd2;
      msr_we = 0; msr_data = 4'h0; cond = 4'hE;
`ifdef APSR_SHADOW_EN
      exc_save = 0; exc_restore = 0;
`endif
   endtask

   // Apply the rules for one rising edge with the current inputs.
   task automatic model_edge();
      bit restore_now;
      bit [3:0] old;
      old = m_nzcv();
      if (rst) return;
      restore_now = 0;
`ifdef APSR_SHADOW_EN
      restore_now = exc_restore && m_sv;
      if (exc_restore) m_sv = 0;
      else if (exc_save) begin m_sh = old; m_sv = 1; end
      if (restore_now) {m_n, m_z, m_c, m_v} = m_sh;
`endif
      if (restore_now) return;
      if (msr_we) begin
         {m_n, m_z, m_c, m_v} = msr_data;
         return;
      end
      if (flag_we_nz) begin
         m_n = alu_result[31];
         m_z = (alu_result == 0);
      end
      if (flag_we_c) begin
         if (c_src_sel == 0) m_c = alu_cout;
         else if (c_src_sel == 1) m_c = shift_cout;
      end
      if (flag_we_v) m_v = alu_vout;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_nzcv"}, apsr_nzcv, m_nzcv());
      chk({tag, "_bits"}, {apsr_n, apsr_z, apsr_c, apsr_v}, m_nzcv());
      chk({tag, "_cond"}, cond_pass, ref_cond(cond, m_n, m_z, m_c, m_v));
`ifdef APSR_SHADOW_EN
      chk({tag, "_sv"}, shadow_valid, m_sv);
`endif
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic tick(input string tag);
      #1;
      chk({tag, "_pre_cond"}, cond_pass, ref_cond(cond, m_n, m_z, m_c, m_v));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   task automatic clear_model();
      {m_n, m_z, m_c, m_v} = 4'h0;
`ifdef APSR_SHADOW_EN
      m_sh = 4'h0; m_sv = 0;
`endif
   endtask

   initial begin
      clear_inputs();
      clear_model();
      rst = 1;
      repeat (2) @(negedge clk);

      // reset state, AL and EQ
      #1;
      chk("rst_nzcv", apsr_nzcv, 4'h0);
      chk("rst_al", cond_pass, 1'b1);
      cond = 4'h0; #1;
      chk("rst_eq", cond_pass, 1'b0);
`ifdef APSR_SHADOW_EN
      chk("rst_sv", shadow_valid, 1'b0);
`endif

      // writes are ignored while reset is held
      msr_we = 1; msr_data = 4'hF;
      tick("rst_hold");
      rst = 0;
      tick("first_edge");
      clear_inputs();

      // zero result with ALU carry -> 0110, HI fails
      msr_we = 1; msr_data = 4'h0; tick("zero_flags");
      clear_inputs();
      alu_result = 32'h0; alu_cout = 1; flag_we_nz = 1; flag_we_c = 1; c_src_sel = 2'd0;
      cond = 4'h8;
      tick("alu_zero");
      chk("alu_zero_val", apsr_nzcv, 4'b0110);
      chk("alu_zero_hi", cond_pass, 1'b0);
      clear_inputs();

      // MSR beats same-cycle NZ update; GE passes
      msr_we = 1; msr_data = 4'b1001; flag_we_nz = 1; alu_result = 32'h0; cond = 4'hA;
      tick("msr_prio");
      chk("msr_prio_val", apsr_nzcv, 4'b1001);
      chk("msr_prio_ge", cond_pass, 1'b1);
      clear_inputs();

      // shifter carry, then reserved/hold selects keep C
      c_src_sel = 2'd1; shift_cout = 1; flag_we_c = 1; tick("shift_c");
      c_src_sel = 2'd3; shift_cout = 0; alu_cout = 0; tick("rsvd_hold");
      chk("rsvd_hold_c", apsr_c, 1'b1);
      c_src_sel = 2'd2; tick("sel2_hold");
      chk("sel2_hold_c", apsr_c, 1'b1);
      clear_inputs();

      // negative result and overflow
      alu_result = 32'h8000_0000; flag_we_nz = 1; flag_we_v = 1; alu_vout = 1; cond = 4'hB;
      tick("neg_ovf");
      clear_inputs();

      // every condition code against the current flags
      for (int k = 0; k < 16; k++) begin
         cond = k[3:0]; #1;
         chk($sformatf("cond_%0d", k), cond_pass, ref_cond(k, m_n, m_z, m_c, m_v));
      end

`ifdef APSR_SHADOW_EN
      clear_inputs();
      msr_we = 1; msr_data = 4'b1010; tick("sh_setup");
      clear_inputs();
      exc_save = 1; msr_we = 1; msr_data = 4'b0101; tick("sh_save");
      chk("sh_save_live", apsr_nzcv, 4'b0101);
      chk("sh_save_sv", shadow_valid, 1'b1);
      clear_inputs();
      exc_restore = 1; msr_we = 1; msr_data = 4'b1111; tick("sh_restore");
      chk("sh_restore_live", apsr_nzcv, 4'b1010);
      chk("sh_restore_sv", shadow_valid, 1'b0);
      clear_inputs();
      exc_restore = 1; tick("sh_restore2");
      chk("sh_restore2_live", apsr_nzcv, 4'b1010);
      exc_save = 1; tick("sh_both");
      chk("sh_both_sv", shadow_valid, 1'b0);
      clear_inputs();
`endif

      // randomized updates
      for (int i = 0; i < 300; i++) begin
         alu_result = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         alu_cout   = 1'($urandom_range(0, 1));
         alu_vout   = 1'($urandom_range(0, 1));
         shift_cout = 1'($urandom_range(0, 1));
         flag_we_nz = 1'($urandom_range(0, 1));
         flag_we_c  = 1'($urandom_range(0, 1));
         flag_we_v  = 1'($urandom_range(0, 1));
         c_src_sel  = 2'($urandom_range(0, 3));
         msr_we     = ($urandom_range(0, 7) == 0);
         msr_data   = 4'($urandom_range(0, 15));
         cond       = 4'($urandom_range(0, 15));
`ifdef APSR_SHADOW_EN
         exc_save    = ($urandom_range(0, 7) == 0);
         exc_restore = ($urandom_range(0, 7) == 0);
`endif
         tick($sformatf("rnd%0d", i));
      end

      // asynchronous reset between edges
      clear_inputs();
      msr_we = 1; msr_data = 4'b1111; tick("pre_async");
      clear_inputs();
      @(posedge clk); #3;
      rst = 1;
      clear_model();
      #1;
      chk("async_nzcv", apsr_nzcv, 4'h0);
      chk("async_al", cond_pass, 1'b1);
`ifdef APSR_SHADOW_EN
      chk("async_sv", shadow_valid, 1'b0);
`endif
      @(negedge clk);
      rst = 0;
      tick("post_async");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
